// File: rtl/camera_sccb_reader.sv
// SCCB register read master: write phase (DEV_ID, reg_addr), gap, read phase (DEV_ID|1, data byte).
// Optional build macro SCCB_READ_ACK_CHECK_EN enables slave ACK sampling and the sticky ack_err flag.

module camera_sccb_reader #(
    parameter int unsigned QUARTER = 63,
    parameter logic [7:0]  DEV_ID  = 8'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] reg_addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       ack_err,
    output logic       sio_c,
    inout  wire        sio_d
);

    localparam int unsigned   QW     = $clog2(QUARTER);
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BYTE  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qi_q, qi_d;
    logic [3:0]    bit_q, bit_d;
    logic          byte_q, byte_d;
    logic          phase_q, phase_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_low_q, sda_low_d;
    logic          sda_meta_q, sda_sync_q;

    logic          tick_s;
    logic          accept_s;
    logic          sample_s;
    logic          rx_byte_s;
    logic [7:0]    tx_byte_s;
    logic          tx_bit_s;

    // Sequencer: quarter counter, state, bit/byte/phase bookkeeping
    always_comb begin
        state_d  = state_q;
        qcnt_d   = qcnt_q;
        qi_d     = qi_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        phase_d  = phase_q;
        tick_s   = (qcnt_q == Q_LAST);
        accept_s = (state_q == S_IDLE) && start;
        addr_d   = accept_s ? reg_addr : addr_q;

        if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
            qcnt_d = '0;
        end else if (tick_s) begin
            qcnt_d = '0;
        end else begin
            qcnt_d = qcnt_q + QW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    qi_d    = 2'd0;
                    phase_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && (qi_q == 2'd2)) begin
                    state_d = S_BYTE;
                    qi_d    = 2'd0;
                    bit_d   = 4'd0;
                    byte_d  = 1'b0;
                end else if (tick_s) begin
                    qi_d = qi_q + 2'd1;
                end else begin
                    qi_d = qi_q;
                end
            end
            S_BYTE: begin
                if (tick_s && (qi_q == 2'd3)) begin
                    qi_d = 2'd0;
                    if ((bit_q == 4'd8) && byte_q) begin
                        state_d = S_STOP;
                    end else if (bit_q == 4'd8) begin
                        byte_d = 1'b1;
                        bit_d  = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else if (tick_s) begin
                    qi_d = qi_q + 2'd1;
                end else begin
                    qi_d = qi_q;
                end
            end
            S_STOP: begin
                if (tick_s && (qi_q == 2'd2)) begin
                    qi_d    = 2'd0;
                    state_d = phase_q ? S_DONE : S_GAP;
                end else if (tick_s) begin
                    qi_d = qi_q + 2'd1;
                end else begin
                    qi_d = qi_q;
                end
            end
            S_GAP: begin
                if (tick_s && (qi_q == 2'd3)) begin
                    state_d = S_START;
                    qi_d    = 2'd0;
                    phase_d = 1'b1;
                end else if (tick_s) begin
                    qi_d = qi_q + 2'd1;
                end else begin
                    qi_d = qi_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Receive shifter: SDA sampled at the end of the second SCL-low-to-high quarter
    always_comb begin
        sample_s  = (state_q == S_BYTE) && tick_s && (qi_q == 2'd2);
        rx_byte_s = phase_q && byte_q;
        if (sample_s && rx_byte_s && !bit_q[3]) begin
            rx_d = {rx_q[6:0], sda_sync_q};
        end else begin
            rx_d = rx_q;
        end
        busy_d = (state_d == S_START) || (state_d == S_BYTE) ||
                 (state_d == S_STOP)  || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            data_d = rx_q;
        end else begin
            data_d = data_q;
        end
    end

    // Bus levels for the upcoming cycle, derived from next state so the pins are registered
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        if (phase_d) begin
            tx_byte_s = DEV_ID | 8'h01;
        end else if (byte_d) begin
            tx_byte_s = addr_d;
        end else begin
            tx_byte_s = DEV_ID;
        end
        tx_bit_s = tx_byte_s[3'd7 - bit_d[2:0]];
        case (state_d)
            S_START: begin
                case (qi_d)
                    2'd0:    begin scl_d = 1'b1; sda_low_d = 1'b0; end
                    2'd1:    begin scl_d = 1'b1; sda_low_d = 1'b1; end
                    default: begin scl_d = 1'b0; sda_low_d = 1'b1; end
                endcase
            end
            S_BYTE: begin
                // ninth bit and the whole received byte leave SDA released
                scl_d     = qi_d[1];
                sda_low_d = !bit_d[3] && !(phase_d && byte_d) && !tx_bit_s;
            end
            S_STOP: begin
                case (qi_d)
                    2'd0:    begin scl_d = 1'b0; sda_low_d = 1'b1; end
                    2'd1:    begin scl_d = 1'b1; sda_low_d = 1'b1; end
                    default: begin scl_d = 1'b1; sda_low_d = 1'b0; end
                endcase
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            qi_q      <= 2'd0;
            bit_q     <= 4'd0;
            byte_q    <= 1'b0;
            phase_q   <= 1'b0;
            addr_q    <= 8'h00;
            rx_q      <= 8'h00;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qi_q      <= qi_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

    // Two-flop synchronizer on the externally driven SDA line
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            sda_meta_q <= sio_d;
            sda_sync_q <= sda_meta_q;
        end
    end

`ifdef SCCB_READ_ACK_CHECK_EN
    logic ack_err_q, ack_err_d;

    // Sticky ACK error: cleared on accept, set when a sent byte's ninth bit reads high
    always_comb begin
        if (accept_s) begin
            ack_err_d = 1'b0;
        end else if (sample_s && bit_q[3] && !rx_byte_s && sda_sync_q) begin
            ack_err_d = 1'b1;
        end else begin
            ack_err_d = ack_err_q;
        end
    end

    // ACK error register
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack_err_d;
        end
    end

    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;
    assign sio_c    = scl_q;
    assign sio_d    = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: doc/camera_sccb_reader.md
# camera_sccb_reader

SCCB read master for the camera configuration path: issues a two-phase write (device ID, register address) followed by a two-phase read (device ID | 1, data byte), and returns the camera register contents. Sits next to the register-write sender on the same `sio_c`/`sio_d` pins. Used to read back and verify camera configuration after init, with bus access muxed by the top level. Runs on the 25 MHz system clock that also drives `xclk`.

## Interface
Parameters:
- `QUARTER`, 63: clock cycles per quarter SCL period (63 → ~99 kHz SCL at 25 MHz); must be ≥ 2.
- `DEV_ID`, 8'h42: 7-bit address plus write bit; the read phase sends `DEV_ID | 8'h01`.

Ports:
- `clk`  in  1  system clock, 25 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a read; sampled only when `busy` = 0.
- `reg_addr`  in  8  register to read; latched on the accepted `start`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse when `data_out` is valid.
- `data_out`  out  8  last byte read; held until the next `done`.
- `ack_err`  out  1  a slave ACK bit sampled high in the last transaction.
- `sio_c`  out  1  SCCB clock, push-pull.
- `sio_d`  inout  1  SCCB data, open-drain: driven 0 or released to Z. The pull-up sits at the top level.

## Operation
- States: IDLE, START, BYTE, STOP, GAP, DONE. A phase counter (0/1) selects write phase vs read phase.
- Quarter-tick counter runs 0..QUARTER-1. Every state/bit action happens on the tick wrap.
- START (3 quarters): SDA=1/SCL=1 → SDA=0/SCL=1 → SDA=0/SCL=0.
- BYTE (9 bits × 4 quarters, MSB first):
  - q0: SDA updated.
  - q1: SCL low.
  - q2: SCL high. Sample taken at the end of q2.
  - q3: SCL high.
- Write phase sends two bytes: `DEV_ID`, then latched `reg_addr`.
- Read phase sends `DEV_ID|1`, then receives 8 bits with SDA released.
- Ninth bit of each sent byte: master releases SDA and samples the ACK. A sampled 1 sets the sticky `ack_err`.
- Ninth bit of the received byte: master drives NA (SDA released = 1).
- STOP (3 quarters): SDA=0/SCL=0 → SDA=0/SCL=1 → SDA=1/SCL=1.
- GAP: 4 quarters of bus idle between phases.
- DONE: 1 cycle. `data_out` is updated and `done` = 1; then IDLE.
- SDA changes only while SCL is low, except at START/STOP edges.
- Received bits shift in MSB first. A floating bus reads 0xFF.

## Timing
- Reset values: `busy`=0, `done`=0, `data_out`=8'h00, `ack_err`=0, `sio_c`=1, `sio_d`=Z, state IDLE.
- `start` high in IDLE at edge N → `busy`=1 from N+1. START begins at N+1.
- Transaction length is 160 quarters:
  - write phase: 3+36+36+3 = 78;
  - gap: 4;
  - read phase: 78.
- `busy` is high for exactly 160×QUARTER cycles. The `done` cycle follows, with `busy`=0.
- `start` is ignored while `busy`=1, and in the DONE cycle.
- `start` held continuously → the next transaction is accepted the cycle after `done`.
- `ack_err` clears on an accepted `start`.
- `reset` mid-transfer: all outputs return to reset values on the next edge. The bus is released (SCL=1, SDA=Z) with no STOP generated. The bench then sees SCL rise with SDA high.

## Configuration
- `SCCB_READ_ACK_CHECK_EN` defined:
  - ACK bits are sampled and `ack_err` is reported as above;
  - transaction length is unchanged (no abort).
- Undefined:
  - ACK bits are released but not sampled;
  - `ack_err` is tied 0;
  - sampling logic is removed.

## Test plan
- Reset (QUARTER=4): after `reset` deasserts → `sio_c`=1, `sio_d`=Z, `busy`=0, `data_out`=8'h00, `ack_err`=0.
- Read 0x0A, slave model ACKs all bytes and returns 0x76:
  - bytes seen on the wire are 0x42, 0x0A, then 0x43;
  - `data_out`=0x76 and `done` pulse exactly 641 cycles after the `start` edge;
  - `ack_err`=0.
- Protocol monitor over a full read: no SDA change while SCL is high except the 2 START and 2 STOP edges; final NA bit = 1.
- No slave attached (bus floats high) → `data_out`=0xFF. `ack_err`=1 with `SCCB_READ_ACK_CHECK_EN`, 0 without.
- `start` with `reg_addr`=0x11 pulsed mid-transfer of a 0x0A read → ignored, second wire byte remains 0x0A. `reset` at cycle 200 → bus idle next cycle, no `done`.
- `start` held high, reads of 0x12 then 0x3A → second START begins the cycle after the first `done`; both bytes are returned correctly.
